// File: rtl/mux_serializer_pkg.sv
// mux_serializer_pkg: shared state type and serial bit-order helper for the serializer.
package mux_serializer_pkg;

   typedef enum logic {IDLE, SHIFT} ser_state_t;

   function automatic int unsigned bit_index(input int unsigned idx, input int unsigned width,
                                             input bit msb_first);
      return msb_first ? width - 1 - idx : idx;
   endfunction

endpackage

// File: rtl/mux_word_bit_select.sv
// mux_word_bit_select: WIDTH-to-1 bit mux.
module mux_word_bit_select #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0]         d,
   input  logic [$clog2(WIDTH)-1:0] sel,
   output logic                     y
);

   assign y = d[sel];

endmodule

// File: rtl/mux_serializer.sv
// mux_serializer: captures a word over valid/ready and emits it one bit per accepted beat.
module mux_serializer
   import mux_serializer_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_bit,
   output logic             out_last,
   output logic             busy
);

   localparam int IW = $clog2(WIDTH);

   ser_state_t       state;
   logic [IW-1:0]    idx;
   logic [IW-1:0]    sel;
   logic [WIDTH-1:0] data_q;
   logic             shift;
   logic             mux_y;

   assign shift     = state == SHIFT;
   assign out_last  = shift && idx == IW'(WIDTH - 1);
   assign out_valid = shift;
   assign busy      = shift;
   // out_ready -> in_ready is combinational so a new word can land on the last beat
   assign in_ready  = !shift || (out_last && out_ready);
   assign sel       = IW'(bit_index(32'(idx), WIDTH, MSB_FIRST));
   assign out_bit   = shift & mux_y;

   mux_word_bit_select #(.WIDTH(WIDTH)) u_sel (
      .d   (data_q),
      .sel (sel),
      .y   (mux_y)
   );

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state  <= IDLE;
         idx    <= '0;
         data_q <= '0;
      end else if (in_valid && in_ready) begin
         state  <= SHIFT;
         idx    <= '0;
         data_q <= in_data;
      end else if (shift && out_ready) begin
         idx <= out_last ? '0 : idx + 1'b1;
         if (out_last) state <= IDLE;
      end

endmodule

// File: tb/tb_mux_serializer.sv
// tb_mux_serializer: directed and randomized checks of mux_serializer against a bit-queue model.
module tb_mux_serializer;

   logic       clk = 0;
   logic       rst_n = 0;
   logic       iv[3], ir[3], ov[3], ordy[3], ob[3], ol[3], bz[3];
   logic [7:0] d8a, d8b;
   logic [1:0] d2a;
   int         tests = 0;
   int         fails = 0;

   always #5 clk = ~clk;

   mux_serializer #(.WIDTH(8), .MSB_FIRST(1)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .in_data(d8a),
      .out_valid(ov[0]), .out_ready(ordy[0]), .out_bit(ob[0]), .out_last(ol[0]), .busy(bz[0]));
   mux_serializer #(.WIDTH(8), .MSB_FIRST(0)) dut_lsb (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(d8b),
      .out_valid(ov[1]), .out_ready(ordy[1]), .out_bit(ob[1]), .out_last(ol[1]), .busy(bz[1]));
   mux_serializer #(.WIDTH(2), .MSB_FIRST(1)) dut_w2 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .in_data(d2a),
      .out_valid(ov[2]), .out_ready(ordy[2]), .out_bit(ob[2]), .out_last(ol[2]), .busy(bz[2]));

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         iv[i] = 0;
         ordy[i] = 1;
      end
      d8a = 0; d8b = 0; d2a = 0;
      rst_n = 0;
      #1;
      for (int i = 0; i < 3; i++) begin
         tests++;
         if ({ov[i], ob[i], ol[i], bz[i], ir[i]} !== 5'b00001) begin
            fails++;
            $display("FAIL reset[%0d] got v/b/l/busy/rdy=%b exp 00001", i, {ov[i], ob[i], ol[i], bz[i], ir[i]});
         end
      end
      repeat (2) tick();
      rst_n = 1;
      tick();
      tests++;
      if (ir[0] !== 1 || ov[0] !== 0) begin
         fails++;
         $display("FAIL post_reset got rdy=%b v=%b exp rdy=1 v=0", ir[0], ov[0]);
      end
   endtask

   task automatic test_basic();
      logic [7:0] w = 8'hA5;
      iv[0] = 1; d8a = w; ordy[0] = 1;
      #1;
      tests++;
      if (ir[0] !== 1 || ov[0] !== 0) begin
         fails++;
         $display("FAIL basic_idle got rdy=%b v=%b exp 1 0", ir[0], ov[0]);
      end
      tick();
      iv[0] = 0; d8a = 8'h00;
      for (int k = 0; k < 8; k++) begin
         #1;
         tests++;
         if (ov[0] !== 1 || ob[0] !== w[7-k] || ol[0] !== (k == 7) || ir[0] !== (k == 7) || bz[0] !== 1) begin
            fails++;
            $display("FAIL basic_beat%0d got v=%b bit=%b last=%b rdy=%b busy=%b exp 1 %b %b %b 1",
                     k, ov[0], ob[0], ol[0], ir[0], bz[0], w[7-k], k == 7, k == 7);
         end
         tick();
      end
      #1;
      tests++;
      if (ov[0] !== 0 || ir[0] !== 1 || bz[0] !== 0) begin
         fails++;
         $display("FAIL basic_end got v=%b rdy=%b busy=%b exp 0 1 0", ov[0], ir[0], bz[0]);
      end
   endtask

   task automatic test_backpressure();
      logic [7:0] w = 8'hA5;
      int cyc = 0;
      int k = 0;
      bit done = 0;
      iv[0] = 1; d8a = w; ordy[0] = 0;
      tick();
      iv[0] = 0;
      for (int s = 0; s < 3; s++) begin
         #1;
         cyc++;
         tests++;
         if (ov[0] !== 1 || ob[0] !== 1 || ol[0] !== 0 || ir[0] !== 0) begin
            fails++;
            $display("FAIL bp_stall%0d got v=%b bit=%b last=%b rdy=%b exp 1 1 0 0", s, ov[0], ob[0], ol[0], ir[0]);
         end
         tick();
      end
      ordy[0] = 1;
      while (!done && cyc < 50) begin
         #1;
         cyc++;
         tests++;
         if (ob[0] !== w[7-k] || ov[0] !== 1) begin
            fails++;
            $display("FAIL bp_bit%0d got v=%b bit=%b exp 1 %b", k, ov[0], ob[0], w[7-k]);
         end
         done = ol[0] === 1;
         k++;
         tick();
      end
      tests++;
      if (cyc !== 11) begin
         fails++;
         $display("FAIL bp_cycles got %0d exp 11", cyc);
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] s = 16'hA53C;
      iv[0] = 1; d8a = 8'hA5; ordy[0] = 1;
      tick();
      d8a = 8'h3C;
      for (int k = 0; k < 16; k++) begin
         iv[0] = k < 8;
         #1;
         tests++;
         if (ov[0] !== 1 || ob[0] !== s[15-k] || ir[0] !== (k % 8 == 7) || ol[0] !== (k % 8 == 7)) begin
            fails++;
            $display("FAIL b2b_beat%0d got v=%b bit=%b rdy=%b last=%b exp 1 %b %b %b",
                     k, ov[0], ob[0], ir[0], ol[0], s[15-k], k % 8 == 7, k % 8 == 7);
         end
         tick();
      end
      iv[0] = 0;
      #1;
      tests++;
      if (ov[0] !== 0) begin
         fails++;
         $display("FAIL b2b_end got v=%b exp 0", ov[0]);
      end
   endtask

   task automatic test_lsb_first();
      logic [7:0] w = 8'h01;
      iv[1] = 1; d8b = w; ordy[1] = 1;
      tick();
      iv[1] = 0;
      for (int k = 0; k < 8; k++) begin
         #1;
         tests++;
         if (ov[1] !== 1 || ob[1] !== w[k] || ol[1] !== (k == 7)) begin
            fails++;
            $display("FAIL lsb_beat%0d got v=%b bit=%b last=%b exp 1 %b %b", k, ov[1], ob[1], ol[1], w[k], k == 7);
         end
         tick();
      end
   endtask

   task automatic test_reset_midword();
      logic [7:0] w = 8'h80;
      iv[0] = 1; d8a = 8'hFF; ordy[0] = 1;
      tick();
      iv[0] = 0;
      repeat (3) tick();
      rst_n = 0;
      #1;
      tests++;
      if (ov[0] !== 0 || bz[0] !== 0 || ob[0] !== 0 || ol[0] !== 0) begin
         fails++;
         $display("FAIL rst_mid got v=%b busy=%b bit=%b last=%b exp 0 0 0 0", ov[0], bz[0], ob[0], ol[0]);
      end
      tick();
      rst_n = 1;
      #1;
      tests++;
      if (ir[0] !== 1 || ov[0] !== 0) begin
         fails++;
         $display("FAIL rst_release got rdy=%b v=%b exp 1 0", ir[0], ov[0]);
      end
      tick();
      iv[0] = 1; d8a = w;
      tick();
      iv[0] = 0;
      for (int k = 0; k < 8; k++) begin
         #1;
         tests++;
         if (ov[0] !== 1 || ob[0] !== w[7-k]) begin
            fails++;
            $display("FAIL rst_word_beat%0d got v=%b bit=%b exp 1 %b", k, ov[0], ob[0], w[7-k]);
         end
         tick();
      end
   endtask

   task automatic test_width2();
      logic [1:0] w = 2'b10;
      iv[2] = 1; d2a = w; ordy[2] = 1;
      tick();
      iv[2] = 0;
      for (int k = 0; k < 2; k++) begin
         #1;
         tests++;
         if (ov[2] !== 1 || ob[2] !== w[1-k] || ol[2] !== (k == 1) || !(dut_w2.idx < 2)) begin
            fails++;
            $display("FAIL w2_beat%0d got v=%b bit=%b last=%b idx=%0d exp 1 %b %b idx<2",
                     k, ov[2], ob[2], ol[2], dut_w2.idx, w[1-k], k == 1);
         end
         tick();
      end
      #1;
      tests++;
      if (ov[2] !== 0 || ir[2] !== 1) begin
         fails++;
         $display("FAIL w2_end got v=%b rdy=%b exp 0 1", ov[2], ir[2]);
      end
   endtask

   task automatic test_random();
      bit         q[$];
      bit         mr;
      logic [7:0] w;
      for (int c = 0; c < 600; c++) begin
         iv[0] = $urandom_range(0, 2) != 0;
         w = 8'($urandom);
         d8a = w;
         ordy[0] = $urandom_range(0, 3) != 0;
         #1;
         mr = q.size() == 0 || (q.size() == 1 && ordy[0]);
         tests++;
         if (ir[0] !== mr || ov[0] !== (q.size() != 0) ||
             (q.size() != 0 && (ob[0] !== q[0] || ol[0] !== (q.size() == 1)))) begin
            fails++;
            $display("FAIL rand_c%0d got rdy=%b v=%b bit=%b last=%b exp rdy=%b v=%b bit=%b last=%b",
                     c, ir[0], ov[0], ob[0], ol[0], mr, q.size() != 0,
                     q.size() != 0 ? q[0] : 1'b0, q.size() == 1);
         end
         if (ordy[0] && q.size() != 0) void'(q.pop_front());
         if (iv[0] && mr)
            for (int j = 7; j >= 0; j--) q.push_back(w[j]);
         tick();
      end
      iv[0] = 0; ordy[0] = 1;
      repeat (10) tick();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_back_to_back();
      test_lsb_first();
      test_width2();
      test_random();
      test_reset_midword();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
